byte_serial_add_ctrl: RTL



---
 rtl/arith_pkg.sv | 12 +
 rtl/add8_slice.sv | 24 ++
 rtl/byte_serial_add_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the byte-serial arithmetic unit: FSM encoding and slice width.
package arith_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add8_slice.sv
// Combinational 8-bit ripple-carry full-adder slice, time-shared by the serial adder.
module add8_slice
  import arith_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              ci,
  output logic [BYTE_W-1:0] s,
  output logic              co
);

  logic carry;

  always_comb begin
    s     = '0;
    carry = ci;
    for (int unsigned i = 0; i < BYTE_W; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// 32-bit add/subtract computed one byte per cycle (LSB first) through a single
// 8-bit slice, with valid/ready handshakes on operands and result.
module byte_serial_add_ctrl
  import arith_pkg::*;
#(
  parameter int W  = 32,
  parameter int NB = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int KW     = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW_LOG = $clog2(BYTE_W);

  state_t state, state_next;

  logic [KW-1:0]        k;
  logic [KW+BW_LOG-1:0] base;
  logic [W-1:0]         x_reg;
  logic [W-1:0]         y_eff;
  logic [W-1:0]         s_reg;
  logic                 c_reg;
  logic                 cout_reg;
  logic                 ovf_reg;

  logic [BYTE_W-1:0]    a_byte;
  logic [BYTE_W-1:0]    b_byte;
  logic [BYTE_W-1:0]    sum_byte;
  logic                 slice_co;
  logic                 accept;
  logic                 last;

  // Bit offset of the active byte: k * BYTE_W.
  assign base   = {k, {BW_LOG{1'b0}}};
  assign a_byte = x_reg[base +: BYTE_W];
  assign b_byte = y_eff[base +: BYTE_W];

  add8_slice u_slice (
    .a  (a_byte),
    .b  (b_byte),
    .ci (c_reg),
    .s  (sum_byte),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        last = (k == KW'(NB - 1));
        if (last) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;

  // Subtraction is folded into the add path as x + ~y + 1, so the slice never
  // needs to know the mode after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg    <= '0;
      y_eff    <= '0;
      s_reg    <= '0;
      c_reg    <= 1'b0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      k        <= '0;
    end else if (accept) begin
      x_reg <= x;
      y_eff <= sub ? ~y : y;
      c_reg <= sub | cin;
      k     <= '0;
    end else if (state == ST_RUN) begin
      s_reg[base +: BYTE_W] <= sum_byte;
      c_reg                 <= slice_co;
      if (last) begin
        k        <= '0;
        cout_reg <= slice_co;
        ovf_reg  <= (x_reg[W-1] == y_eff[W-1]) && (sum_byte[BYTE_W-1] != x_reg[W-1]);
      end else begin
        k <= k + KW'(1);
      end
    end
  end

  assign s    = s_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule
